div_seq32: RTL
==============

Name: div_seq32

Overview:
- Multi-cycle radix-2 restoring divider that sits directly under the execute-stage ALU.
- The ALU drives `start` for DIV/DIVU and holds the pipeline via its stall output until `ready`.
- Produces {remainder, quotient}; the ALU routes the upper half to HI and the lower half to LO.
- Handles signed and unsigned division, divide-by-zero and annul (flush from exception/branch).

Parameters:
- WIDTH, 32, operand width in bits. The result is 2*WIDTH wide. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled at operand capture
- opdata1  input  WIDTH  dividend; sampled at operand capture
- opdata2  input  WIDTH  divisor; sampled at operand capture
- start  input  1  request/hold; level-sensitive
- annul  input  1  abort an in-progress division
- result  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
- ready  output  1  result valid

Behaviour:
- Reset: asynchronous, active-high. Clears to IDLE with ready=0, result=0, counter=0 and all operand/partial registers 0. It takes effect mid-operation with no completion pulse.
- States: IDLE, BYZERO, ON, END. The state is registered. ready is 1 only in END.
- IDLE:
  - start=1 and annul=0 at edge T0: capture operands and sign flags.
  - If the latched divisor is 0, go to BYZERO. Otherwise go to ON with counter=0.
  - start=0: stay in IDLE, result holds its last value.
- Operand capture:
  - When signed_div=1, negative operands are converted to magnitude (~x+1). The flags neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend) are stored.
  - Inputs may change freely after T0. The latched copies alone are used, so the ALU needs no divisor latch.
- ON:
  - Each edge performs one restoring step on a WIDTH+1-bit partial remainder: shift in the next dividend MSB, trial-subtract the divisor, and keep the result if it is non-negative.
  - Quotient bit = 1 when the trial subtraction is kept. counter increments.
  - On the edge that completes iteration WIDTH-1 (edge T0+WIDTH), go to END. Apply sign fixup to the quotient if neg_q and to the remainder if neg_r, then load result.
  - ready is first visible after edge T0+WIDTH, i.e. 32 cycles after capture.
- BYZERO: next edge (T0+1) goes to END with result=0 (the architecture leaves this undefined; we fix it at 0).
- END:
  - ready=1 and result is stable.
  - start=0: go to IDLE next edge, ready drops, result holds.
  - start=1: stay in END with ready=1 and no restart. A new division requires start low for at least 1 cycle.
- annul:
  - annul=1 in ON or BYZERO: go to IDLE next edge. ready is never asserted and result is unchanged.
  - annul=1 in IDLE blocks capture.
  - annul=1 in END: go to IDLE.
  - annul has priority over start.
- Arithmetic:
  - Quotient truncates toward zero. The remainder has the dividend's sign, with |r| < |divisor|.
  - Signed 0x80000000 / 0xFFFFFFFF wraps to q=0x80000000, r=0. The magnitude path must treat 0x80000000 as unsigned 2^31.
- start/ready contract with the ALU:
  - The ALU deasserts start combinationally when ready=1, so END normally lasts exactly 1 cycle.
  - The ALU writes HI/LO in that cycle.

Test Plan:
- Unsigned 100 / 7, start held: ready rises 32 cycles after capture with result={0x00000002,0x0000000E}. Drop start and ready falls next cycle.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002): result={0xFFFFFFFF,0xFFFFFFFD}. Signed 7 / -2 gives {0x00000001,0xFFFFFFFD}.
- Signed 0x80000000 / 0xFFFFFFFF gives {0,0x80000000}. Unsigned 0xFFFFFFFF / 1 gives {0,0xFFFFFFFF}. Unsigned 5 / 9 gives {5,0}.
- Divisor 0: ready after 2 edges (BYZERO→END), result=0. Change opdata2 to nonzero after T0: the result is still 0.
- annul=1 at iteration 10: IDLE next cycle, ready stays 0, prior result unchanged. An immediate new start of 20/3 gives {2,6} in 32 cycles.
- Assert rst asynchronously mid-ON (between edges): state IDLE, ready=0, result=0 without a clock edge. Holding start through END keeps ready=1 with no restart.

Source files
------------

// File: rtl/div_seq32.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// result = {remainder, quotient}; ready is high only in END.
module div_seq32 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     rem_shift, trial;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_keep, quo_step, quo_fix, rem_fix;

    always_comb begin
        // Magnitudes are unsigned, so 0x80000000 stays 2^31 here.
        abs_a = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
        abs_b = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;

        // dvd_q shifts dividend bits out of the top and quotient bits in at the bottom.
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvs_q};
        q_bit     = ~trial[WIDTH];
        rem_keep  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_step  = {dvd_q[WIDTH-2:0], q_bit};
        quo_fix   = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
        rem_fix   = neg_rem_q ? (~rem_keep + 1'b1) : rem_keep;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    dvd_d     = abs_a;
                    dvs_d     = abs_b;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    neg_rem_d = signed_div & opdata1[WIDTH-1];
                    state_d   = (abs_b == '0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    state_d  = END;
                    result_d = '0;
                end
            end
            ON: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    dvd_d = quo_step;
                    rem_d = rem_keep;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d  = END;
                        result_d = {rem_fix, quo_fix};
                    end
                end
            end
            END: begin
                // Holding start keeps END; a new division needs start low first.
                if (annul || !start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;
    assign ready  = (state_q == END);

endmodule
